// File: rtl/button_event_tx_pkg.sv
// rtl/button_event_tx_pkg.sv - shared chunk types, payload layout and FSM encoding for the button event transmitter
package button_event_tx_pkg;

  localparam logic [7:0] RX_VIRTUAL_BUTTONS_CHUNK_TYPE = 8'd3;
  localparam logic [7:0] TX_BUTTON_EVENT_CHUNK_TYPE    = 8'd4;

  localparam int BYTE_OFFSET_INDEX   = 0;
  localparam int BYTE_OFFSET_LEVEL   = 1;
  localparam int EVENT_PAYLOAD_BYTES = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } tx_state_t;

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - 2-flop synchroniser plus debounce counter for one button
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic toggle
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // Combinational so the parent captures the event on the same edge the level flips.
  assign toggle = (sync != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (sync == stable) begin
        cnt <= '0;
      end else if (toggle) begin
        cnt    <= '0;
        stable <= ~stable;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_event_tx.sv
// rtl/button_event_tx.sv - debounced button edges turned into 2-byte TX chunks with round-robin arbitration
module button_event_tx
  import button_event_tx_pkg::*;
#(
  parameter int INTERFACE_TX_CHUNK_TYPE      = int'(TX_BUTTON_EVENT_CHUNK_TYPE),
  parameter int TX_CONTENT_BUFFER_BYTE_SIZE  = 3,
  parameter int TX_CONTENT_BUFFER_INDEX_SIZE = 32,
  parameter int NUM_BUTTONS                  = 4,
  parameter int DEBOUNCE_CYCLES              = 16
) (
  input  logic                                     CLK,
  input  logic                                     RST_N,
  input  logic [NUM_BUTTONS-1:0]                   buttons,
  output logic [7:0]                               tx_chunk_type,
  output logic [TX_CONTENT_BUFFER_BYTE_SIZE*8-1:0] tx_chunk_bytes,
  output logic [TX_CONTENT_BUFFER_INDEX_SIZE-1:0]  tx_chunk_byte_size,
  output logic                                     tx_is_chunk_ready,
  input  logic                                     tx_chunk_taken,
  output logic [7:0]                               dropped_events
);

  localparam int SEL_W = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
  localparam int PW    = TX_CONTENT_BUFFER_BYTE_SIZE * 8;

  logic [NUM_BUTTONS-1:0] stable;
  logic [NUM_BUTTONS-1:0] flip;
  logic [NUM_BUTTONS-1:0] pending;
  logic [NUM_BUTTONS-1:0] pending_n;
  logic [NUM_BUTTONS-1:0] ev_level;
  logic [NUM_BUTTONS-1:0] ev_level_n;
  logic [SEL_W-1:0]       rr_ptr;
  logic [SEL_W-1:0]       sel;
  logic [SEL_W:0]         idx;
  logic                   any;
  logic                   load;
  logic [9:0]             drop_sum;
  logic [9:0]             drop_total;
  logic [7:0]             dropped_n;
  logic [PW-1:0]          payload_n;
  tx_state_t              state;
  tx_state_t              state_n;

  assign tx_chunk_type = 8'(INTERFACE_TX_CHUNK_TYPE);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (CLK),
      .rst_n (RST_N),
      .raw   (buttons[i]),
      .stable(stable[i]),
      .toggle(flip[i])
    );
  end

  // Scan downwards so the last hit is the nearest pending index at or after rr_ptr.
  always_comb begin
    any = 1'b0;
    sel = '0;
    idx = '0;
    for (int k = NUM_BUTTONS - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (SEL_W + 1)'(k);
      if (idx >= (SEL_W + 1)'(NUM_BUTTONS)) idx = idx - (SEL_W + 1)'(NUM_BUTTONS);
      if (pending[idx[SEL_W-1:0]]) begin
        any = 1'b1;
        sel = idx[SEL_W-1:0];
      end
    end
  end

  assign load = (state == ST_IDLE) && any;

  // A new flip overrides the arbiter's clear; it is a drop only if the old event was not just taken.
  always_comb begin
    pending_n  = pending;
    ev_level_n = ev_level;
    drop_sum   = '0;
    if (load) pending_n[sel] = 1'b0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (flip[i]) begin
        if (pending[i] && !(load && sel == SEL_W'(i))) drop_sum = drop_sum + 10'd1;
        pending_n[i]  = 1'b1;
        ev_level_n[i] = ~stable[i];
      end
    end
    drop_total = {2'b00, dropped_events} + drop_sum;
    dropped_n  = (drop_total > 10'd255) ? 8'hFF : drop_total[7:0];
  end

  always_comb begin
    payload_n = '0;
    payload_n[BYTE_OFFSET_INDEX*8 +: 8] = 8'(sel);
    payload_n[BYTE_OFFSET_LEVEL*8 +: 8] = {7'd0, ev_level[sel]};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (any) state_n = ST_OFFER;
      ST_OFFER: if (tx_chunk_taken) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_is_chunk_ready = (state == ST_OFFER);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending            <= '0;
      ev_level           <= '0;
      rr_ptr             <= '0;
      dropped_events     <= '0;
      tx_chunk_bytes     <= '0;
      tx_chunk_byte_size <= '0;
    end else begin
      pending        <= pending_n;
      ev_level       <= ev_level_n;
      dropped_events <= dropped_n;
      if (load) begin
        tx_chunk_bytes     <= payload_n;
        tx_chunk_byte_size <= TX_CONTENT_BUFFER_INDEX_SIZE'(EVENT_PAYLOAD_BYTES);
        rr_ptr             <= (sel == SEL_W'(NUM_BUTTONS - 1)) ? '0 : sel + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_button_event_tx.sv
// tb/tb_button_event_tx.sv - directed and randomized self-checking bench for button_event_tx
module tb_button_event_tx;

  localparam int D = 16;
  localparam int N = 4;
  localparam int BYTES = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     buttons;
  logic [7:0]       tx_chunk_type;
  logic [BYTES*8-1:0] tx_chunk_bytes;
  logic [31:0]      tx_chunk_byte_size;
  logic             tx_is_chunk_ready;
  logic             tx_chunk_taken;
  logic [7:0]       dropped_events;

  int   checks = 0;
  int   errors = 0;
  logic auto_take = 1'b0;
  logic force_take = 1'b0;

  typedef struct {
    logic [23:0] bytes;
    logic [31:0] size;
    logic [7:0]  ctype;
  } chunk_t;
  chunk_t got[$];

  always #5 clk = ~clk;

  button_event_tx #(
    .INTERFACE_TX_CHUNK_TYPE     (4),
    .TX_CONTENT_BUFFER_BYTE_SIZE (BYTES),
    .TX_CONTENT_BUFFER_INDEX_SIZE(32),
    .NUM_BUTTONS                 (N),
    .DEBOUNCE_CYCLES             (D)
  ) dut (
    .CLK               (clk),
    .RST_N             (rst_n),
    .buttons           (buttons),
    .tx_chunk_type     (tx_chunk_type),
    .tx_chunk_bytes    (tx_chunk_bytes),
    .tx_chunk_byte_size(tx_chunk_byte_size),
    .tx_is_chunk_ready (tx_is_chunk_ready),
    .tx_chunk_taken    (tx_chunk_taken),
    .dropped_events    (dropped_events)
  );

  // Serialiser model: accepts on the edge following a visible offer when auto_take is set.
  initial begin
    tx_chunk_taken = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tx_chunk_taken = (auto_take & tx_is_chunk_ready) | force_take;
    end
  end

  always @(negedge clk) begin
    if (rst_n && tx_is_chunk_ready && tx_chunk_taken)
      got.push_back('{bytes: tx_chunk_bytes, size: tx_chunk_byte_size, ctype: tx_chunk_type});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_chunk(input string tag, input logic [23:0] exp);
    chunk_t c;
    int w = 0;
    while (got.size() == 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_present"}, 32'(got.size() > 0), 32'd1);
    if (got.size() > 0) begin
      c = got.pop_front();
      check({tag, "_bytes"}, 32'(c.bytes), 32'(exp));
      check({tag, "_size"}, c.size, 32'd2);
      check({tag, "_type"}, 32'(c.ctype), 32'd4);
    end
  endtask

  task automatic expect_none(input string tag, input int n);
    cycles(n);
    check(tag, 32'(got.size()), 32'd0);
    got.delete();
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (!tx_is_chunk_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check(tag, 32'(tx_is_chunk_ready), 32'd1);
  endtask

  initial begin
    logic [N-1:0] lvl;
    int lat;
    int b;

    rst_n   = 1'b0;
    buttons = '0;
    cycles(3);
    check("reset_ready", 32'(tx_is_chunk_ready), 32'd0);
    check("reset_bytes", 32'(tx_chunk_bytes), 32'd0);
    check("reset_size", tx_chunk_byte_size, 32'd0);
    check("reset_type", 32'(tx_chunk_type), 32'd4);
    check("reset_dropped", 32'(dropped_events), 32'd0);
    rst_n = 1'b1;
    cycles(2);

    // Taken while idle must do nothing.
    force_take = 1'b1;
    cycles(4);
    check("idle_taken_ready", 32'(tx_is_chunk_ready), 32'd0);
    force_take = 1'b0;
    expect_none("idle_taken_nochunk", 40);

    // Simultaneous presses with rr_ptr at 0, then simultaneous releases.
    auto_take = 1'b1;
    buttons = 4'b1001;
    expect_chunk("rr_first", 24'h000100);
    expect_chunk("rr_second", 24'h000103);
    buttons = 4'b0000;
    expect_chunk("rel_first", 24'h000000);
    expect_chunk("rel_second", 24'h000003);

    // Glitch shorter than the debounce window.
    buttons[1] = 1'b1;
    cycles(10);
    buttons[1] = 1'b0;
    expect_none("glitch_nochunk", 60);
    check("glitch_dropped", 32'(dropped_events), 32'd0);

    // Press-to-ready latency on button 2.
    buttons[2] = 1'b1;
    lat = 0;
    while (!tx_is_chunk_ready && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat >= 2 + D + 1 && lat <= 2 + D + 2), 32'd1);
    expect_chunk("press2", 24'h000102);

    // Stalled serialiser: payload held, button 1 coalesced, buttons 0 then 3 queued.
    auto_take = 1'b0;
    buttons[2] = 1'b0;
    wait_ready("stall_ready");
    for (int c = 0; c < 100; c++) begin
      if (c == 5)  buttons[1] = 1'b1;
      if (c == 30) buttons[1] = 1'b0;
      if (c == 55) buttons[0] = 1'b1;
      if (c == 65) buttons[3] = 1'b1;
      @(negedge clk);
      check("stall_payload", 32'(tx_chunk_bytes), 32'h000002);
      check("stall_ready_held", 32'(tx_is_chunk_ready), 32'd1);
    end
    check("stall_dropped", 32'(dropped_events), 32'd1);
    auto_take = 1'b1;
    expect_chunk("stall_release2", 24'h000002);
    expect_chunk("rr_three_first", 24'h000103);
    expect_chunk("rr_zero_next", 24'h000100);
    expect_chunk("coalesced1", 24'h000001);

    // Randomized single-button toggles and glitches against the level model.
    lvl = buttons;
    for (int it = 0; it < 24; it++) begin
      b = int'($urandom_range(0, N - 1));
      if ($urandom_range(0, 2) == 0) begin
        buttons[b] = ~lvl[b];
        cycles(int'($urandom_range(1, D - 3)));
        buttons[b] = lvl[b];
        expect_none("rand_glitch", 2 * D + 8);
      end else begin
        lvl[b] = ~lvl[b];
        buttons[b] = lvl[b];
        expect_chunk("rand_toggle", {8'h00, 7'h00, lvl[b], 8'(b)});
        cycles(3);
      end
    end
    check("rand_dropped", 32'(dropped_events), 32'd1);

    // Reset while offering with another event pending.
    auto_take = 1'b0;
    buttons[1] = ~buttons[1];
    wait_ready("pre_reset_offer");
    buttons[2] = ~buttons[2];
    cycles(2 + D + 4);
    buttons = '0;
    rst_n = 1'b0;
    #1;
    check("async_reset_ready", 32'(tx_is_chunk_ready), 32'd0);
    check("async_reset_bytes", 32'(tx_chunk_bytes), 32'd0);
    check("async_reset_dropped", 32'(dropped_events), 32'd0);
    cycles(2);
    got.delete();
    rst_n = 1'b1;
    auto_take = 1'b1;
    expect_none("post_reset_nochunk", 3 * D + 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
